// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared constants and types for the data-side memory system
package data_bus_pkg;

   localparam logic [31:0] UART_DATA_ADDR = 32'hFFFF_0000;
   localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_0004;
   localparam logic [31:0] CYCLE_ADDR     = 32'hFFFF_0008;

   localparam int STAT_FULL = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_OVF  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/data_bus_uart_tx.sv
// rtl/data_bus_uart_tx.sv - buffered UART transmitter: TX FIFO feeding an 8N1 serializer
module uart_tx
   import data_bus_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] data,
   output logic [7:0] count,
   output logic       full,
   input  logic       ovf_clr,
   output logic       ovf,
   output logic       busy,
   output logic       txd
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;

   uart_state_t   state, state_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          pop, accept, bit_end, not_empty;

   assign not_empty = (cnt != '0);
   assign full      = (cnt == CW'(FIFO_DEPTH));
   assign busy      = not_empty || (state != IDLE);
   assign count     = 8'(cnt);
   assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   // a pop on the same edge frees the slot, so a push into a full FIFO still lands
   assign accept    = push && (!full || pop);

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      pop       = 1'b0;
      txd       = 1'b1;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               baud_nxt  = '0;
               state_nxt = START;
            end
         end
         START: begin
            txd = 1'b0;
            if (bit_end) begin
               baud_nxt  = '0;
               bit_nxt   = '0;
               state_nxt = DATA;
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         DATA: begin
            txd = shreg[0];
            if (bit_end) begin
               baud_nxt  = '0;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) state_nxt = STOP;
               else                 bit_nxt   = bit_cnt + 3'd1;
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (not_empty) begin
                  pop       = 1'b1;
                  shreg_nxt = mem[rd_ptr];
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         case ({accept, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (push && !accept) ovf <= 1'b1;
         else if (ovf_clr)    ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && accept) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/data_bus.sv
// rtl/data_bus.sv - data RAM plus UART/cycle-counter peripheral page for the core's load/store port
// Optional CYCLE counter is built only when DATA_BUS_CYCLE_CNT_EN is defined.
module data_bus
   import data_bus_pkg::*;
#(
   parameter int RAM_WORDS    = 1024,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [31:0] daddr,
   input  logic [31:0] din,
   input  logic        MemWrite,
   output logic [31:0] dout,
   output logic        uart_txd
);

   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] word_addr, cyc_val, stat_val;
   logic        ram_hit, data_hit, stat_hit, cyc_hit;
   logic [7:0]  fifo_count;
   logic        fifo_full, ovf, busy;
   logic        unused_byte_sel;

   assign unused_byte_sel = &{1'b0, daddr[1:0]};
   assign word_addr = {daddr[31:2], 2'b00};
   // out-of-range words must not alias onto low RAM, hence the full index compare
   assign ram_hit  = (daddr[31:16] == 16'h0000) &&
                     (({16'h0000, daddr[15:0]} >> 2) < 32'(RAM_WORDS));
   assign data_hit = (word_addr == UART_DATA_ADDR);
   assign stat_hit = (word_addr == UART_STAT_ADDR);
   assign cyc_hit  = (word_addr == CYCLE_ADDR);

   always_ff @(posedge sys_clk) begin
      if (MemWrite && ram_hit) ram[daddr[AW+1:2]] <= din;
   end

   uart_tx #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .push   (MemWrite && data_hit),
      .data   (din[7:0]),
      .count  (fifo_count),
      .full   (fifo_full),
      .ovf_clr(MemWrite && stat_hit && din[STAT_OVF]),
      .ovf    (ovf),
      .busy   (busy),
      .txd    (uart_txd)
   );

`ifdef DATA_BUS_CYCLE_CNT_EN
   logic [31:0] cycle;
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) cycle <= '0;
      else            cycle <= cycle + 32'd1;
   end
   assign cyc_val = cycle;
`else
   assign cyc_val = '0;
`endif

   assign stat_val = {16'h0000, fifo_count, 5'b00000, ovf, busy, fifo_full};

   always_comb begin
      dout = '0;
      if (ram_hit)       dout = ram[daddr[AW+1:2]];
      else if (stat_hit) dout = stat_val;
      else if (cyc_hit)  dout = cyc_val;
   end

endmodule

// File: tb/tb_data_bus.sv
// tb/tb_data_bus.sv - scoreboard bench for data_bus: RAM, UART framing, overflow, reset, cycle counter
module tb_data_bus;

   localparam int RAM_WORDS = 1024;
   localparam int FIFO_DEPTH = 8;
   localparam int CPB = 4;
   localparam logic [31:0] A_DATA = 32'hFFFF_0000;
   localparam logic [31:0] A_STAT = 32'hFFFF_0004;
   localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [31:0] daddr, din, dout;
   logic        MemWrite, uart_txd;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   data_bus #(
      .RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .CLKS_PER_BIT(CPB)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .daddr(daddr), .din(din),
      .MemWrite(MemWrite), .dout(dout), .uart_txd(uart_txd)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] b);
      for (int i = 0; i < CPB; i++) exp_q.push_back(32'd0);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < CPB; i++) exp_q.push_back({31'd0, b[k]});
      for (int i = 0; i < CPB; i++) exp_q.push_back(32'd1);
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; MemWrite = 1'b0; daddr = '0; din = '0;
      repeat (3) tick();
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
      daddr = A_STAT; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h expected 00000000", dout); end
      daddr = A_CYC; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL reset_cycle: got %h expected 00000000", dout); end
      daddr = A_DATA; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL reset_uart_data_read: got %h expected 00000000", dout); end
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ram();
      logic [31:0] addrs [4] = '{32'h0000_0010, 32'h0000_0000, 32'h0000_0FFC, 32'h0000_0044};
      logic [31:0] vals  [4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0F0F, 32'h0000_0001};
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         daddr = addrs[i]; din = vals[i]; MemWrite = 1'b1;
         exp_q.push_back(vals[i]);
         tick();
         MemWrite = 1'b0;
         e = exp_q.pop_front();
         #1; checks++;
         if (dout !== e) begin errors++; $display("FAIL ram_load %h: got %h expected %h", daddr, dout, e); end
      end
      daddr = 32'h0000_0013; #1; checks++;
      if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_byte_offset: got %h expected deadbeef", dout); end
   endtask

   task automatic test_ram_range();
      daddr = 32'h0000_1000; din = 32'hCAFE_F00D; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL ram_out_of_range: got %h expected 00000000", dout); end
      daddr = 32'h0000_0000; #1; checks++;
      if (dout !== 32'h1234_5678) begin errors++; $display("FAIL ram_word0_kept: got %h expected 12345678", dout); end
      daddr = 32'hFFFF_0010; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", dout); end
   endtask

   task automatic test_uart_frame();
      int n = 0;
      exp_q.delete();
      daddr = A_DATA; din = 32'h0000_0055; MemWrite = 1'b1;
      exp_q.push_back(32'd1);
      push_frame(8'h55);
      tick();
      MemWrite = 1'b0; daddr = A_STAT;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (uart_txd !== e[0]) begin errors++; $display("FAIL uart_frame sample %0d: got %b expected %b", n, uart_txd, e[0]); end
         n++;
         tick();
      end
      checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL uart_idle_stat: got %h expected 00000000", dout); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      exp_q.delete();
      daddr = A_DATA; din = 32'h0000_000F; MemWrite = 1'b1;
      exp_q.push_back(32'd1);
      push_frame(8'h0F);
      push_frame(8'hC3);
      exp_q.push_back(32'd1);
      tick();
      e = exp_q.pop_front(); checks++;
      if (uart_txd !== e[0]) begin errors++; $display("FAIL b2b pre-start: got %b expected %b", uart_txd, e[0]); end
      din = 32'h0000_00C3;
      tick();
      MemWrite = 1'b0; daddr = A_STAT;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (uart_txd !== e[0]) begin errors++; $display("FAIL b2b sample %0d: got %b expected %b", n, uart_txd, e[0]); end
         n++;
         tick();
      end
      checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL b2b_idle_stat: got %h expected 00000000", dout); end
   endtask

   task automatic test_overflow();
      int  m_cnt = 0;
      bit  m_ser = 0, m_ovf = 0, pop;
      exp_q.delete();
      daddr = A_DATA; MemWrite = 1'b1;
      for (int i = 0; i < 10; i++) begin
         din = 32'(i);
         pop = !m_ser && (m_cnt > 0);
         if (pop) begin m_ser = 1; m_cnt--; end
         if (m_cnt < FIFO_DEPTH) m_cnt++;
         else m_ovf = 1;
         tick();
      end
      exp_q.push_back({16'h0, 8'(m_cnt), 5'b0, m_ovf, 1'b1, (m_cnt == FIFO_DEPTH)});
      MemWrite = 1'b0; daddr = A_STAT; #1;
      e = exp_q.pop_front(); checks++;
      if (dout !== e) begin errors++; $display("FAIL ovf_stat: got %h expected %h", dout, e); end
      checks++;
      if (dout !== 32'h0000_0807) begin errors++; $display("FAIL ovf_nine_accepted: got %h expected 00000807", dout); end
      din = 32'd4; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0; #1; checks++;
      if (dout !== 32'h0000_0803) begin errors++; $display("FAIL ovf_clear: got %h expected 00000803", dout); end
   endtask

   task automatic test_reset_mid_frame();
      sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1;
      daddr = A_DATA; din = 32'h0000_005A; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      repeat (7) tick();
      checks++;
      if (uart_txd !== 1'b0) begin errors++; $display("FAIL mid_frame_bit0: got %b expected 0", uart_txd); end
      sys_rst_n = 1'b0;
      tick();
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_abort_txd: got %b expected 1", uart_txd); end
      daddr = A_STAT; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL reset_abort_stat: got %h expected 00000000", dout); end
      daddr = A_CYC; #1; checks++;
      if (dout !== 32'h0) begin errors++; $display("FAIL reset_abort_cycle: got %h expected 00000000", dout); end
      sys_rst_n = 1'b1;
   endtask

   task automatic test_cycle();
      logic [31:0] c1, c2;
      sys_rst_n = 1'b0; daddr = A_CYC; tick(); sys_rst_n = 1'b1;
      repeat (5) tick();
      c1 = dout;
      repeat (100) tick();
      c2 = dout;
`ifdef DATA_BUS_CYCLE_CNT_EN
      checks++;
      if (c1 !== 32'd5) begin errors++; $display("FAIL cycle_at_5: got %0d expected 5", c1); end
      checks++;
      if (c2 - c1 !== 32'd100) begin errors++; $display("FAIL cycle_delta: got %0d expected 100", c2 - c1); end
`else
      checks++;
      if (c1 !== 32'd0) begin errors++; $display("FAIL cycle_disabled_a: got %h expected 0", c1); end
      checks++;
      if (c2 !== 32'd0) begin errors++; $display("FAIL cycle_disabled_b: got %h expected 0", c2); end
`endif
   endtask

   initial begin
      test_reset();
      test_ram();
      test_ram_range();
      test_uart_frame();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
